// File: rtl/mem_arb_pkg.sv
// Shared types and reset constants for the I/D single-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam arb_state_t RST_STATE      = IDLE;
    localparam arb_owner_t RST_LAST_OWNER = OWN_I;
    localparam logic       RST_CTRL       = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between eligible I and D requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise D has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic elig_i,
    input  logic elig_d,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_valid = elig_i | elig_d;
        grant_owner = elig_d ? OWN_D : OWN_I;
        // On conflict the side that did not own the port last time wins
        if (elig_i && elig_d)
            grant_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant_valid = elig_i | elig_d;
        grant_owner = elig_d ? OWN_D : OWN_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-side refills and D-side accesses onto one memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: D priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t state;
    logic       last_owner;
    logic       elig_i, elig_d;
    logic       grant_valid, grant_owner;

    // A request whose done is pulsing right now is being retired, not renewed
    assign elig_i = i_req & ~i_done;
    assign elig_d = d_req & ~d_done;

`ifndef MEM_ARB_RR_EN
    assign last_owner = RST_LAST_OWNER;
`endif

    mem_arb_pick u_pick (
        .elig_i      (elig_i),
        .elig_d      (elig_d),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= RST_STATE;
            mem_en    <= RST_CTRL;
            mem_we    <= RST_CTRL;
            i_done    <= RST_CTRL;
            d_done    <= RST_CTRL;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner <= RST_LAST_OWNER;
`endif
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_en <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_owner <= grant_owner;
`endif
                        if (grant_owner == OWN_D) begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            state     <= D_BUSY;
                        end else begin
                            // I fetches are reads; mem_wdata keeps its last value
                            mem_addr <= i_addr;
                            mem_we   <= 1'b0;
                            state    <= I_BUSY;
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (mem_ready) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= IDLE;
                        if (state == I_BUSY) begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
